// File: rtl/core_clock_req_ctrl.sv
// Clock-request sequencer for the core clock gate: drains the bus, waits a hold-off
// window before dropping clk_req, and waits a warm-up window after raising it again.
module core_clock_req_ctrl #(
   parameter int unsigned HOLDOFF_CYCLES = 4,
   parameter int unsigned WAKE_CYCLES    = 2,
   parameter int unsigned CW             = 4
) (
   input  logic       g_clk,
   input  logic       g_resetn,
   input  logic       sleep_req,
   input  logic       bus_idle,
   input  logic       wake_src,
   input  logic       force_on,
   output logic       clk_req,
   output logic       sleep_ack,
   output logic       wake_done,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_DRAIN   = 3'd1,
      ST_HOLDOFF = 3'd2,
      ST_SLEEP   = 3'd3,
      ST_WAKE    = 3'd4
   } state_t;

   localparam logic [CW-1:0] HOLDOFF_LOAD = CW'(HOLDOFF_CYCLES - 1);
   localparam logic [CW-1:0] WAKE_LOAD    = CW'(WAKE_CYCLES - 1);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_clk_req;
   logic          r_sleep_ack;
   logic          r_wake_done;

   state_t        w_state_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_hold;
   logic          w_clk_req_nxt;
   logic          w_sleep_ack_nxt;
   logic          w_wake_done_nxt;

   assign w_hold = wake_src | force_on;

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         r_state     <= ST_RUN;
         r_cnt       <= '0;
         r_clk_req   <= 1'b1;
         r_sleep_ack <= 1'b0;
         r_wake_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_clk_req   <= w_clk_req_nxt;
         r_sleep_ack <= w_sleep_ack_nxt;
         r_wake_done <= w_wake_done_nxt;
      end
   end

   // Hold has priority over drain/count progress; the counter never wraps below zero.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_RUN: begin
            if (sleep_req && !w_hold) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_hold) begin
               w_state_nxt = ST_RUN;
            end else if (bus_idle) begin
               w_state_nxt = ST_HOLDOFF;
               w_cnt_nxt   = HOLDOFF_LOAD;
            end
         end
         ST_HOLDOFF: begin
            if (w_hold || !sleep_req) begin
               w_state_nxt = ST_RUN;
            end else if (!bus_idle) begin
               w_state_nxt = ST_DRAIN;
            end else if (r_cnt == '0) begin
               w_state_nxt = ST_SLEEP;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         ST_SLEEP: begin
            if (w_hold) begin
               w_state_nxt = ST_WAKE;
               w_cnt_nxt   = WAKE_LOAD;
            end
         end
         ST_WAKE: begin
            if (r_cnt == '0) w_state_nxt = ST_RUN;
            else             w_cnt_nxt   = r_cnt - 1'b1;
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   // Outputs are derived from the next state so they register on the same edge as it.
   always_comb begin
      w_clk_req_nxt   = (w_state_nxt != ST_SLEEP);
      w_sleep_ack_nxt = (w_state_nxt == ST_SLEEP);
      w_wake_done_nxt = (r_state == ST_WAKE) && (w_state_nxt == ST_RUN);
   end

   assign clk_req   = r_clk_req;
   assign sleep_ack = r_sleep_ack;
   assign wake_done = r_wake_done;
   assign state_dbg = r_state;

endmodule
